// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: BTB counter encoding, PC step,
// BTB entry layout and the saturating-counter update rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_pkg;

    // 2-bit saturating branch counter states; bit 1 set means predict taken.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

    // The tag field is sized for the smallest BTB (4 entries -> 28 tag bits).
    // Larger BTBs store their narrower tag zero-extended into this field.
    localparam int TAG_MAX_W = 28;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    // Move one step toward ST on taken, toward SNT on not taken, saturating.
    function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Latency: lookup combinational; update visible the cycle after iUpdate.
// Backpressure: none; update port is always accepted, lookup is always valid.
//
// Ports:
//   iClk, iRstN       clock, async active-low reset (clears valid, ctr=WNT)
//   iLookupPC         fetch PC to look up
//   oHit/oTarget/oTaken  lookup result; oTaken = hit && ctr[1]
//   iUpdate, iUpdatePC, iUpdateTaken, iUpdateTarget  resolution from execute
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:0] iLookupPC,
    output logic        oHit,
    output logic [31:0] oTarget,
    output logic        oTaken,
    input  logic        iUpdate,
    input  logic [31:0] iUpdatePC,
    input  logic        iUpdateTaken,
    input  logic [31:0] iUpdateTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    btb_entry_t entries [BTB_ENTRIES];

    logic [IDX_W-1:0]     lkIdx;
    logic [TAG_MAX_W-1:0] lkTag;
    logic [IDX_W-1:0]     updIdx;
    logic [TAG_MAX_W-1:0] updTag;
    logic                 updHit;
    btb_entry_t           lkEntry;
    btb_entry_t           updEntry;

    // Byte-offset bits never take part in indexing or tagging.
    logic [3:0] unusedLsbs;
    assign unusedLsbs = {iLookupPC[1:0], iUpdatePC[1:0]};

    assign lkIdx  = iLookupPC[IDX_W+1:2];
    assign lkTag  = TAG_MAX_W'(iLookupPC[31:IDX_W+2]);
    assign updIdx = iUpdatePC[IDX_W+1:2];
    assign updTag = TAG_MAX_W'(iUpdatePC[31:IDX_W+2]);

    // Lookup reads the array before this cycle's update lands, so a same-index
    // update and lookup see the old contents.
    assign lkEntry  = entries[lkIdx];
    assign oHit     = lkEntry.valid && (lkEntry.tag == lkTag);
    assign oTarget  = lkEntry.target;
    assign oTaken   = oHit && lkEntry.ctr[1];

    assign updEntry = entries[updIdx];
    assign updHit   = updEntry.valid && (updEntry.tag == updTag);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (iUpdate) begin
            if (updHit) begin
                entries[updIdx].ctr <= ctrNext(updEntry.ctr, iUpdateTaken);
                if (iUpdateTaken) begin
                    entries[updIdx].target <= iUpdateTarget;
                end
            end else if (iUpdateTaken) begin
                // Taken miss replaces whatever occupied the slot.
                entries[updIdx] <= '{valid: 1'b1, tag: updTag,
                                     target: iUpdateTarget, ctr: WT};
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch-stage front end: PC register, next-PC select and BTB prediction.
// Latency: imem address/instruction/prediction combinational from PC; PC 1 cycle.
// Backpressure: iStallF holds the PC; iRedirectE overrides the stall.
//
// Ports:
//   iClk, iRstN        clock, async active-low reset (PC = RESET_PC)
//   iStallF            hold PC
//   iRedirectE/iRedirectPCE   redirect from execute
//   iUpdateE/iUpdatePCE/iUpdateTakenE/iUpdateTargetE  BTB training
//   iImemRdata         combinational instruction memory read data
//   oImemAddr, oInstructionF, oPCF, oTakeJBF  fetch outputs to F->D
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStallF,
    input  logic        iRedirectE,
    input  logic [31:0] iRedirectPCE,
    input  logic        iUpdateE,
    input  logic [31:0] iUpdatePCE,
    input  logic        iUpdateTakenE,
    input  logic [31:0] iUpdateTargetE,
    input  logic [31:0] iImemRdata,
    output logic [31:0] oImemAddr,
    output logic [31:0] oInstructionF,
    output logic [31:0] oPCF,
    output logic        oTakeJBF
);

    logic [31:0] pcF;
    logic [31:0] pcNext;
    logic        btbHit;
    logic [31:0] btbTarget;
    logic        btbTaken;

    fetch_btb #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) uBtb (
        .iClk         (iClk),
        .iRstN        (iRstN),
        .iLookupPC    (pcF),
        .oHit         (btbHit),
        .oTarget      (btbTarget),
        .oTaken       (btbTaken),
        .iUpdate      (iUpdateE),
        .iUpdatePC    (iUpdatePCE),
        .iUpdateTaken (iUpdateTakenE),
        .iUpdateTarget(iUpdateTargetE)
    );

    // Hit is folded into btbTaken; kept as a named signal for debug visibility.
    logic unusedHit;
    assign unusedHit = btbHit;

    // Redirect beats stall; stall beats prediction. Sequential add wraps at 2^32.
    always_comb begin
        pcNext = pcF + PC_STEP;
        if (iRedirectE) begin
            pcNext = iRedirectPCE;
        end else if (iStallF) begin
            pcNext = pcF;
        end else if (btbTaken) begin
            pcNext = btbTarget;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            pcF <= RESET_PC;
        end else begin
            pcF <= pcNext;
        end
    end

    assign oPCF          = pcF;
    assign oImemAddr     = pcF;
    assign oInstructionF = iImemRdata;
    assign oTakeJBF      = btbTaken;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        iClk;
    logic        iRstN;
    logic        iStallF;
    logic        iRedirectE;
    logic [31:0] iRedirectPCE;
    logic        iUpdateE;
    logic [31:0] iUpdatePCE;
    logic        iUpdateTakenE;
    logic [31:0] iUpdateTargetE;
    logic [31:0] iImemRdata;
    logic [31:0] oImemAddr;
    logic [31:0] oInstructionF;
    logic [31:0] oPCF;
    logic        oTakeJBF;

    int total = 0;
    int bad   = 0;

    fetch_stage #(
        .BTB_ENTRIES(16),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .iClk          (iClk),
        .iRstN         (iRstN),
        .iStallF       (iStallF),
        .iRedirectE    (iRedirectE),
        .iRedirectPCE  (iRedirectPCE),
        .iUpdateE      (iUpdateE),
        .iUpdatePCE    (iUpdatePCE),
        .iUpdateTakenE (iUpdateTakenE),
        .iUpdateTargetE(iUpdateTargetE),
        .iImemRdata    (iImemRdata),
        .oImemAddr     (oImemAddr),
        .oInstructionF (oInstructionF),
        .oPCF          (oPCF),
        .oTakeJBF      (oTakeJBF)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setUpd(input logic en, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt);
        iUpdateE       = en;
        iUpdatePCE     = pc;
        iUpdateTakenE  = tk;
        iUpdateTargetE = tgt;
    endtask

    task automatic setRedir(input logic en, input logic [31:0] pc);
        iRedirectE   = en;
        iRedirectPCE = pc;
    endtask

    initial begin
        iRstN      = 1'b0;
        iStallF    = 1'b0;
        iImemRdata = 32'hCAFE_F00D;
        setRedir(1'b0, 32'h0);
        setUpd(1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state
        #12;
        chk("rst_pc",    oPCF,           32'h0);
        chk("rst_addr",  oImemAddr,      32'h0);
        chk("rst_take",  {31'b0, oTakeJBF}, 32'h0);
        chk("rst_instr", oInstructionF,  32'hCAFE_F00D);
        iRstN = 1'b1;

        // Free run
        step(); chk("run_pc4",  oPCF, 32'h4);
        step(); chk("run_pc8",  oPCF, 32'h8);
        step(); chk("run_pc12", oPCF, 32'hC);
        chk("run_take", {31'b0, oTakeJBF}, 32'h0);

        // Asynchronous reset mid-run, no clock edge needed
        #2 iRstN = 1'b0;
        #1 chk("async_rst_pc", oPCF, 32'h0);
        step(); chk("rst_hold_pc", oPCF, 32'h0);
        iRstN = 1'b1;
        step(); chk("post_rst_pc", oPCF, 32'h4);

        // Train 0x10 taken -> 0x40 (allocates at WT)
        setUpd(1'b1, 32'h10, 1'b1, 32'h40);
        step(); chk("train_pc", oPCF, 32'h8);
        setUpd(1'b0, 32'h0, 1'b0, 32'h0);
        setRedir(1'b1, 32'h10);
        step(); chk("redir_pc10", oPCF, 32'h10);
        setRedir(1'b0, 32'h0);
        chk("hit_take", {31'b0, oTakeJBF}, 32'h1);
        step(); chk("pred_target", oPCF, 32'h40);
        chk("target_take", {31'b0, oTakeJBF}, 32'h0);

        // Two not-taken: WT -> WNT -> SNT
        setUpd(1'b1, 32'h10, 1'b0, 32'h0);
        step(); step();
        setUpd(1'b0, 32'h0, 1'b0, 32'h0);
        setRedir(1'b1, 32'h10);
        step(); chk("snt_pc", oPCF, 32'h10);
        setRedir(1'b0, 32'h0);
        chk("snt_take", {31'b0, oTakeJBF}, 32'h0);
        step(); chk("snt_next", oPCF, 32'h14);

        // Further not-taken stays SNT; one taken then reaches only WNT
        setUpd(1'b1, 32'h10, 1'b0, 32'h0);
        step();
        setUpd(1'b1, 32'h10, 1'b1, 32'h80);
        step();
        setUpd(1'b0, 32'h0, 1'b0, 32'h0);
        setRedir(1'b1, 32'h10);
        step(); chk("sat_pc", oPCF, 32'h10);
        setRedir(1'b0, 32'h0);
        chk("sat_take", {31'b0, oTakeJBF}, 32'h0);

        // Same-cycle update+lookup sees old contents; stall holds PC
        iStallF = 1'b1;
        setUpd(1'b1, 32'h10, 1'b1, 32'h80);
        #1 chk("same_cyc_old", {31'b0, oTakeJBF}, 32'h0);
        step(); chk("stall_pc_a", oPCF, 32'h10);
        chk("new_take", {31'b0, oTakeJBF}, 32'h1);
        setUpd(1'b0, 32'h0, 1'b0, 32'h0);
        step(); chk("stall_pc_b", oPCF, 32'h10);
        chk("stall_take", {31'b0, oTakeJBF}, 32'h1);
        chk("stall_addr", oImemAddr, 32'h10);
        iStallF = 1'b0;
        step(); chk("retarget", oPCF, 32'h80);

        // Redirect overrides stall, then plain stall for 3 cycles
        iStallF = 1'b1;
        setRedir(1'b1, 32'h200);
        step(); chk("redir_stall", oPCF, 32'h200);
        setRedir(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall3", oPCF, 32'h200);
        end
        iStallF = 1'b0;
        step(); chk("unstall", oPCF, 32'h204);

        // Aliasing: 0x50 shares index 4 with 0x10 but has a different tag
        setRedir(1'b1, 32'h50);
        step(); chk("alias_pc", oPCF, 32'h50);
        setRedir(1'b0, 32'h0);
        chk("alias_take", {31'b0, oTakeJBF}, 32'h0);
        step(); chk("alias_next", oPCF, 32'h54);
        setUpd(1'b1, 32'h50, 1'b1, 32'h100);
        setRedir(1'b1, 32'h50);
        step(); chk("alloc_pc", oPCF, 32'h50);
        setUpd(1'b0, 32'h0, 1'b0, 32'h0);
        setRedir(1'b0, 32'h0);
        chk("alloc_take", {31'b0, oTakeJBF}, 32'h1);
        step(); chk("alloc_target", oPCF, 32'h100);
        setRedir(1'b1, 32'h10);
        step(); chk("evicted_pc", oPCF, 32'h10);
        setRedir(1'b0, 32'h0);
        chk("evicted_take", {31'b0, oTakeJBF}, 32'h0);
        step(); chk("evicted_next", oPCF, 32'h14);

        // Wrap at the top of the address space
        setRedir(1'b1, 32'hFFFF_FFFC);
        step(); chk("wrap_pc", oPCF, 32'hFFFF_FFFC);
        setRedir(1'b0, 32'h0);
        chk("wrap_take", {31'b0, oTakeJBF}, 32'h0);
        step(); chk("wrap_next", oPCF, 32'h0);

        // Instruction word is passed straight through
        iImemRdata = 32'h1234_5678;
        #1 chk("instr_pass", oInstructionF, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch-stage front end that produces the instruction, PC and predicted-jump flag consumed by the F→D pipeline register. It holds the architectural fetch PC, drives the instruction-memory address, and predicts taken branches/jumps with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It accepts stall and redirect control from the hazard unit and resolution updates from the execute stage.

## Interface
- BTB_ENTRIES, 16: number of BTB entries; power of two, 4..64.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous, active-low reset
- iStallF  in  1  hold PC; no new fetch
- iRedirectE  in  1  misprediction or redirect from execute; overrides stall
- iRedirectPCE  in  32  correct next PC when iRedirectE=1
- iUpdateE  in  1  a branch/jump resolved in execute this cycle
- iUpdatePCE  in  32  PC of the resolved branch/jump
- iUpdateTakenE  in  1  actual outcome
- iUpdateTargetE  in  32  actual target address
- iImemRdata  in  32  instruction-memory read data for oImemAddr (combinational read)
- oImemAddr  out  32  instruction-memory address (= oPCF)
- oInstructionF  out  32  fetched instruction (= iImemRdata)
- oPCF  out  32  current fetch PC
- oTakeJBF  out  1  prediction for oPCF: 1 = predicted taken

## Operation
- Index = PC[IDX+1:2], IDX = log2(BTB_ENTRIES); tag = PC[31:IDX+2]. PC[1:0] is ignored.
- Each entry stores valid, tag, 32-bit target and a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational on oPCF. hit = valid && tag match. oTakeJBF = hit && counter[1].
- Next-PC priority, highest first:
  - iRedirectE: iRedirectPCE.
  - iStallF: hold.
  - oTakeJBF: BTB target.
  - Otherwise oPCF + 4, 32-bit wrap (32'hFFFF_FFFC → 32'h0).
- Update on iUpdateE is independent of iStallF and iRedirectE:
  - Hit on iUpdatePCE: counter increments when taken and decrements when not, saturating at ST/SNT. Target is rewritten when taken.
  - Miss and taken: allocate and overwrite. Set valid=1, tag, target, counter=WT.
  - Miss and not taken: no change.
- Reset (asynchronous, any time including mid-stall or mid-update):
  - oPCF = RESET_PC.
  - All valid bits = 0 and all counters = WNT.
  - Therefore oTakeJBF = 0 and oImemAddr = RESET_PC.
  - oInstructionF follows iImemRdata.
- The BTB holds no data path; it never alters the instruction word.

## Timing
- PC register and BTB update on the rising edge of iClk. Asynchronous clear on the falling edge of iRstN.
- Prediction has zero bubbles: a taken prediction at cycle N gives oPCF = target at N+1.
- Redirect asserted at cycle N gives oPCF = iRedirectPCE at N+1, even with iStallF=1.
- Stall at cycle N gives oPCF, oTakeJBF and oImemAddr unchanged at N+1, provided the BTB entry is not updated.
- An update and a lookup to the same index in the same cycle: the lookup sees old contents. The new contents are visible from N+1.
- After reset deasserts, the first edge advances the PC by normal next-PC rules.

## Structure
- Shared package fetch_pkg:
  - Counter encoding localparams: SNT, WNT, WT, ST.
  - PC_STEP = 32'd4.
  - typedef btb_entry_t {valid, tag, target, ctr}. Tag width is derived from the parameter inside the module.
- One sub-module, fetch_btb:
  - Owns the entry array, the lookup port (PC → hit, target, taken) and the update port.
  - Handles reset of its own state.
- fetch_stage keeps the PC register and next-PC mux.

## Test plan
- Reset then free-run with no updates: oPCF = 0, 4, 8, 12; oTakeJBF = 0 throughout. Assert iRstN=0 mid-run: oPCF goes to 0 immediately, without waiting for a clock edge.
- Update PC=0x10, taken, target=0x40. On the next pass through 0x10: oTakeJBF = 1 and the following oPCF = 0x40 (counter WT).
- Same entry, two not-taken updates: counter goes WT→WNT→SNT. The next fetch of 0x10 has oTakeJBF = 0 and the next PC is 0x14. A further not-taken update stays at SNT.
- iStallF=1 and iRedirectE=1 with iRedirectPCE=0x200 in the same cycle: next oPCF = 0x200. With iStallF alone for 3 cycles, oPCF is held.
- Aliasing (BTB_ENTRIES=16): train 0x10 taken to 0x40, then fetch 0x50 (same index, different tag). Result is a miss, oTakeJBF = 0, next PC 0x54. A taken update at 0x50 replaces the entry.
- Wrap: redirect to 0xFFFF_FFFC, no hit → next oPCF = 0x0000_0000.
